// File: rtl/clock_meter_pkg.sv
// Shared definitions for the slow-clock period meter: FSM state encoding and
// the default counter width.
package clock_meter_pkg;

  localparam int DEFAULT_CNT_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    MEASURE = 2'b10
  } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous slow clock into the local domain through a flop chain
// and flags the cycle in which its synchronised level first goes high.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic slow_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], slow_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period and high time of a slow asynchronous clock in local
// clock cycles, with a sticky timeout when the slow clock stops toggling.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 slow_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic s;
  logic rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .slow_in(slow_in),
    .s      (s),
    .rise   (rise)
  );

  meter_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
  logic                 period_valid_q, period_valid_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;

  logic [CNT_WIDTH-1:0] cnt_inc, hcnt_inc;
  logic                 expired;

  assign cnt_inc  = (cnt_q  == CNT_MAX) ? cnt_q  : cnt_q  + CNT_ONE;
  assign hcnt_inc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_ONE;
  // A rise in the expiry cycle takes priority, so expiry is only acted on without one.
  assign expired  = (cnt_q == TIMEOUT_VAL);

  // NOTE: every signal written below gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hcnt_d         = hcnt_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = timeout_q;

    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ARM;
          cnt_d     = '0;
          hcnt_d    = '0;
          locked_d  = 1'b0;
          timeout_d = 1'b0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end else if (expired) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
            hcnt_d    = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d       = cnt_q;
            high_time_d    = hcnt_q;
            period_valid_d = 1'b1;
            locked_d       = 1'b1;
            timeout_d      = 1'b0;
            cnt_d          = CNT_ONE;
            hcnt_d         = CNT_ONE;
          end else if (expired) begin
            state_d   = ARM;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
            hcnt_d    = '0;
          end else begin
            cnt_d = cnt_inc;
            if (s) hcnt_d = hcnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      hcnt_q         <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hcnt_q         <= hcnt_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: reset, steady lock, duty change,
// timeout and recovery, enable drop, and asynchronous reset mid-measurement.
module tb_clock_period_meter;

  localparam int CW = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          slow_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          locked;
  logic          timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  int gen_hi = 4;
  int gen_lo = 4;
  int gen_ph = 0;
  bit gen_on = 1'b0;

  clock_period_meter #(
    .CNT_WIDTH     (CW),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .slow_in     (slow_in),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  initial forever #5 clock = ~clock;

  // Slow clock: gen_hi cycles high then gen_lo low, updated on falling edges.
  initial forever begin
    @(negedge clock);
    if (gen_on) begin
      slow_in = (gen_ph < gen_hi);
      gen_ph  = (gen_ph + 1 == gen_hi + gen_lo) ? 0 : gen_ph + 1;
    end else begin
      slow_in = 1'b0;
    end
  end

  initial forever begin
    @(posedge clock);
    #2;
    if (period_valid === 1'b1) pulse_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Returns the number of falling edges until period_valid is seen, -1 if none.
  task automatic wait_pulse(input string tag, input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clock);
      if (period_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
    check({tag, " pulse seen"}, 32'(cyc > 0), 32'd1);
  endtask

  task automatic gen_set(input int hi, input int lo, input bit on);
    @(posedge clock);
    #1;
    gen_hi = hi;
    gen_lo = lo;
    gen_ph = 0;
    gen_on = on;
  endtask

  initial begin
    int cyc;
    int p0;

    // 1: reset held while slow_in toggles, then released idle
    reset  = 1'b0;
    enable = 1'b1;
    gen_hi = 2;
    gen_lo = 2;
    gen_on = 1'b1;
    repeat (6) @(negedge clock);
    check("rst period", 32'(period), 0);
    check("rst high_time", 32'(high_time), 0);
    check("rst locked", 32'(locked), 0);
    check("rst timeout", 32'(timeout), 0);
    check("rst pulses", pulse_cnt, 0);
    reset  = 1'b1;
    enable = 1'b0;
    gen_on = 1'b0;
    repeat (4) @(negedge clock);
    check("rel period", 32'(period), 0);
    check("rel locked", 32'(locked), 0);
    check("rel pulses", pulse_cnt, 0);

    // 2: 4 high / 4 low, first rise silent, then a pulse every 8 cycles
    @(posedge clock);
    #1;
    enable = 1'b1;
    gen_hi = 4;
    gen_lo = 4;
    gen_ph = 0;
    gen_on = 1'b1;
    repeat (6) @(negedge clock);
    check("t2 first rise no pulse", pulse_cnt, 0);
    check("t2 not locked yet", 32'(locked), 0);
    wait_pulse("t2 p1", 16, cyc);
    check("t2 period", 32'(period), 8);
    check("t2 high_time", 32'(high_time), 4);
    check("t2 locked", 32'(locked), 1);
    @(negedge clock);
    check("t2 pulse width", 32'(period_valid), 0);
    wait_pulse("t2 p2", 10, cyc);
    check("t2 spacing", cyc, 7);
    check("t2 period again", 32'(period), 8);

    // 3: duty change to 3 high / 7 low
    gen_set(3, 7, 1'b1);
    wait_pulse("t3 p1", 30, cyc);
    wait_pulse("t3 p2", 20, cyc);
    check("t3 period", 32'(period), 10);
    check("t3 high_time", 32'(high_time), 3);
    wait_pulse("t3 p3", 20, cyc);
    check("t3 spacing", cyc, 10);
    check("t3 high_time again", 32'(high_time), 3);

    // 4: lock at period 8, stop slow_in, timeout exactly 100 cycles after last rise
    gen_set(4, 4, 1'b1);
    wait_pulse("t4 p1", 30, cyc);
    wait_pulse("t4 p2", 20, cyc);
    check("t4 lock period", 32'(period), 8);
    gen_on = 1'b0;
    p0 = pulse_cnt;
    repeat (99) @(negedge clock);
    check("t4 no timeout before limit", 32'(timeout), 0);
    check("t4 still locked", 32'(locked), 1);
    @(negedge clock);
    check("t4 timeout", 32'(timeout), 1);
    check("t4 unlocked", 32'(locked), 0);
    check("t4 no pulse", pulse_cnt, p0);
    check("t4 period holds", 32'(period), 8);
    repeat (30) @(negedge clock);
    check("t4 timeout sticky", 32'(timeout), 1);
    gen_set(4, 4, 1'b1);
    p0 = pulse_cnt;
    repeat (6) @(negedge clock);
    check("t4 resume first rise no pulse", pulse_cnt, p0);
    check("t4 timeout until pulse", 32'(timeout), 1);
    wait_pulse("t4 resume", 16, cyc);
    check("t4 resume period", 32'(period), 8);
    check("t4 resume high_time", 32'(high_time), 4);
    check("t4 timeout cleared", 32'(timeout), 0);
    check("t4 relocked", 32'(locked), 1);

    // 5: drop enable for one cycle right after a pulse
    enable = 1'b0;
    @(negedge clock);
    check("t5 unlocked", 32'(locked), 0);
    check("t5 period holds", 32'(period), 8);
    check("t5 no pulse in idle", 32'(period_valid), 0);
    enable = 1'b1;
    wait_pulse("t5 rearm", 24, cyc);
    check("t5 pulse at second rise", cyc, 15);
    check("t5 period", 32'(period), 8);
    check("t5 locked", 32'(locked), 1);

    // 6: asynchronous reset between clock edges mid-measurement
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("t6 async period", 32'(period), 0);
    check("t6 async high_time", 32'(high_time), 0);
    check("t6 async locked", 32'(locked), 0);
    check("t6 async timeout", 32'(timeout), 0);
    check("t6 async pulse", 32'(period_valid), 0);
    @(negedge clock);
    check("t6 held period", 32'(period), 0);
    reset = 1'b1;
    wait_pulse("t6 recover", 24, cyc);
    check("t6 recover latency", cyc, 12);
    check("t6 recover period", 32'(period), 8);
    check("t6 recover high_time", 32'(high_time), 4);
    check("t6 recover locked", 32'(locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
